shield_damage_ctrl: RTL and testbench
=====================================

SHIELD_DAMAGE_CTRL -- requirements
Module: shield_damage_ctrl

Interface
REQ-001 SHALL have parameter HIT_POINTS, default 3 (1..3), hits needed to destroy one shield cell.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4 (power of 2), erase-command queue depth.
REQ-003 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  one clock; reset is synchronous and active-high.
REQ-005 SHALL have port startOfFrame  in  1  one-cycle pulse at the start of each video frame.
REQ-006 SHALL have port offsetX  in  11  pixel offset from the shield-area top-left corner.
REQ-007 SHALL have port offsetY  in  11  pixel offset from the shield-area top-left corner.
REQ-008 SHALL have port insideRectangle  in  1  current pixel lies in the shield area.
REQ-009 SHALL have port collisionMissile  in  1  monster missile overlaps a shield pixel this cycle.
REQ-010 SHALL have port collisionShot  in  1  player shot overlaps a shield pixel this cycle.
REQ-011 SHALL have port rdRow/rdCol  in  2/5  health read address.
REQ-012 SHALL have port rdHealth  out  2  health of the addressed cell, registered.
REQ-013 SHALL have port eraseValid/eraseRow/eraseCol  out  1/2/5  erase command to the shields bitmap.
REQ-014 SHALL have port eraseReady  in  1  bitmap accepts the erase command.
REQ-015 SHALL have port aliveCount  out  7  number of cells with health > 0.
REQ-016 SHALL have port allDestroyed/overflow  out  1/1  all cells dead / sticky queue-overflow flag.

Function
REQ-017 SHALL model a grid of 4 rows x 18 columns of 32x16-pixel cells: row = offsetY[5:4], col = offsetX[9:5].
REQ-018 SHALL treat a hit as (collisionMissile or enabled collisionShot) and insideRectangle and col <= 17; a hit on col > 17 is ignored.
REQ-019 SHALL decrement a cell's health by at most 1 per frame; a per-cell hitThisFrame bit blocks further hits until the next startOfFrame clears it.
REQ-020 SHALL apply startOfFrame before a hit in the same cycle, so that hit counts in the new frame.
REQ-021 SHALL update health on the edge after the hit cycle (latency 1) and ignore hits on cells already at 0.
REQ-022 SHALL push {row,col} into the erase FIFO on the same edge on which health goes 1 -> 0, and decrement aliveCount on that edge.
REQ-023 SHALL drive eraseValid high while the FIFO is non-empty, with eraseRow/eraseCol taken from the head entry.
REQ-024 SHALL pop the head on every edge where eraseValid and eraseReady are both high; the head SHALL stay stable while eraseReady is low.
REQ-025 SHALL still zero the health when the FIFO is full and a push is needed, drop the entry, and set overflow until reset.
REQ-026 SHALL, when a push and a pop occur on the same edge, perform both, with occupancy unchanged.
REQ-027 SHALL return rdHealth for (rdRow,rdCol) one cycle later, and return 0 for rdCol > 17.
REQ-028 SHALL drive allDestroyed = (aliveCount == 0) combinationally.

Reset
REQ-029 SHALL, on reset: all healths = HIT_POINTS, hitThisFrame cleared, FIFO empty, eraseValid 0, aliveCount 72, overflow 0, rdHealth 0.
REQ-030 SHALL, when reset arrives mid-operation, discard queued erases; the bitmap performs its own reset in parallel.

Configuration
REQ-031 SHALL support macro SHIELD_PLAYER_DAMAGE_EN: when defined, collisionShot also damages cells; when undefined, collisionShot is ignored entirely.

Structure
REQ-032 SHALL place the constants SHIELD_ROWS=4, SHIELD_COLS=18, CELL_W_BITS=5, CELL_H_BITS=4 and the typedef shield_cell_t {row,col} in the shared shields package.
REQ-033 SHALL implement the erase queue as sub-module shield_erase_fifo (synchronous, with full/empty outputs).

Verification
REQ-034 SHALL have a bench scenario: reset, then read all cells -> rdHealth=3 everywhere, aliveCount=72, eraseValid=0.
REQ-035 SHALL have a bench scenario: collisionMissile held 20 cycles at offset (70,20) within one frame -> cell(1,2) health 3->2 exactly once.
REQ-036 SHALL have a bench scenario: three frames each hitting (0,0) with eraseReady=1 -> eraseValid pulses once with row 0, col 0; aliveCount=71.
REQ-037 SHALL have a bench scenario: eraseReady=0, 5 cells killed -> first 4 queued in order, overflow=1, aliveCount=67.
REQ-038 SHALL have a bench scenario: startOfFrame and a hit on the same cycle after a prior-frame hit -> second decrement is taken.
REQ-039 SHALL have a bench scenario: collisionShot alone on (0,0) -> health decrements with SHIELD_PLAYER_DAMAGE_EN defined, and is unchanged without it.

Source files
------------

// File: rtl/shields_pkg.sv
// Shared shield constants and types.
//   SHIELD_ROWS x SHIELD_COLS grid of (2^CELL_W_BITS x 2^CELL_H_BITS)-pixel cells.
//   shield_cell_t : {row, col} address of one cell.
//   cell_idx()    : flat index (row-major) of a cell into per-cell arrays.
package shields_pkg;
  localparam int SHIELD_ROWS = 4;
  localparam int SHIELD_COLS = 18;
  localparam int CELL_W_BITS = 5;
  localparam int CELL_H_BITS = 4;
  localparam int NUM_CELLS   = SHIELD_ROWS * SHIELD_COLS;

  typedef struct packed {
    logic [1:0] row;
    logic [4:0] col;
  } shield_cell_t;

  function automatic logic [6:0] cell_idx(input logic [1:0] row, input logic [4:0] col);
    return 7'(row) * 7'(SHIELD_COLS) + 7'(col);
  endfunction
endpackage

// File: rtl/shield_erase_fifo.sv
// Synchronous FIFO of cell addresses waiting to be erased from the bitmap.
// Ports:
//   clk, reset          : clock, synchronous active-high reset (empties queue)
//   push, push_data     : enqueue request; ignored when full unless a pop frees
//                         a slot on the same edge
//   pop                 : dequeue head (ignored when empty)
//   head                : head entry, stable until popped
//   full, empty         : occupancy flags
module shield_erase_fifo
  import shields_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  shield_cell_t push_data,
  input  logic         pop,
  output shield_cell_t head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  shield_cell_t r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          w_do_pop, w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign head      = r_mem[r_rptr];
  assign w_do_pop  = pop & ~empty;
  // A pop on the same edge makes room, so a full queue can still accept.
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= push_data;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_do_pop) r_rptr <= r_rptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - (AW+1)'(1);
    end
  end
endmodule

// File: rtl/shield_damage_ctrl.sv
// Shield damage controller: tracks per-cell health of the 4x18 shield grid,
// applies at most one hit per cell per frame, and queues erase commands for
// cells that die.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   startOfFrame                    : frame pulse, re-arms every cell for a hit
//   offsetX/offsetY/insideRectangle : current pixel position in the shield area
//   collisionMissile/collisionShot  : collision strobes for the current pixel
//   rdRow/rdCol -> rdHealth         : registered health read (0 for col > 17)
//   eraseValid/Row/Col, eraseReady  : erase command handshake to the bitmap
//   aliveCount, allDestroyed        : live-cell count and all-dead flag
//   overflow                        : sticky, an erase was dropped (queue full)
// Config macro: SHIELD_PLAYER_DAMAGE_EN -- when defined collisionShot also
// damages cells; otherwise it is ignored.
module shield_damage_ctrl
  import shields_pkg::*;
#(
  parameter int HIT_POINTS = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic [10:0] offsetX,
  input  logic [10:0] offsetY,
  input  logic        insideRectangle,
  input  logic        collisionMissile,
  input  logic        collisionShot,
  input  logic [1:0]  rdRow,
  input  logic [4:0]  rdCol,
  output logic [1:0]  rdHealth,
  output logic        eraseValid,
  output logic [1:0]  eraseRow,
  output logic [4:0]  eraseCol,
  input  logic        eraseReady,
  output logic [6:0]  aliveCount,
  output logic        allDestroyed,
  output logic        overflow
);
  logic [1:0]           r_health [NUM_CELLS];
  logic [NUM_CELLS-1:0] r_hit;
  logic [6:0]           r_alive;
  logic                 r_overflow;

  logic [1:0]   w_row;
  logic [4:0]   w_col;
  logic [6:0]   w_idx;
  logic         w_shot, w_hit, w_hit_ok, w_kill, w_pop, w_full, w_empty;
  shield_cell_t w_cell, w_head;
  logic         w_unused;

`ifdef SHIELD_PLAYER_DAMAGE_EN
  assign w_shot   = collisionShot;
  assign w_unused = ^{offsetX[10], offsetX[4:0], offsetY[10:6], offsetY[3:0]};
`else
  assign w_shot   = 1'b0;
  assign w_unused = ^{offsetX[10], offsetX[4:0], offsetY[10:6], offsetY[3:0], collisionShot};
`endif

  assign w_row  = offsetY[CELL_H_BITS+1:CELL_H_BITS];
  assign w_col  = offsetX[CELL_W_BITS+4:CELL_W_BITS];
  assign w_idx  = cell_idx(w_row, w_col);
  assign w_cell = '{row: w_row, col: w_col};

  assign w_hit    = (collisionMissile | w_shot) & insideRectangle
                  & (w_col <= 5'(SHIELD_COLS-1));
  // startOfFrame re-arms the cell in the same cycle, so its hit flag is moot.
  assign w_hit_ok = w_hit & (startOfFrame | ~r_hit[w_idx]) & (r_health[w_idx] != 2'd0);
  assign w_kill   = w_hit_ok & (r_health[w_idx] == 2'd1);
  assign w_pop    = eraseValid & eraseReady;

  shield_erase_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_kill),
    .push_data (w_cell),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign eraseValid   = ~w_empty;
  assign eraseRow     = w_head.row;
  assign eraseCol     = w_head.col;
  assign aliveCount   = r_alive;
  assign allDestroyed = (r_alive == 7'd0);
  assign overflow     = r_overflow;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CELLS; i++) r_health[i] <= 2'(HIT_POINTS);
      r_hit      <= '0;
      r_alive    <= 7'(NUM_CELLS);
      r_overflow <= 1'b0;
      rdHealth   <= 2'd0;
    end else begin
      if (startOfFrame) r_hit <= '0;
      // Later NBA wins, so a hit on the frame-start cycle stays recorded.
      if (w_hit_ok) begin
        r_hit[w_idx]    <= 1'b1;
        r_health[w_idx] <= r_health[w_idx] - 2'd1;
      end
      if (w_kill) r_alive <= r_alive - 7'd1;
      // Cell still dies; only its erase command is lost.
      if (w_kill && w_full && !w_pop) r_overflow <= 1'b1;
      rdHealth <= (rdCol <= 5'(SHIELD_COLS-1)) ? r_health[cell_idx(rdRow, rdCol)] : 2'd0;
    end
  end
endmodule

// File: tb/tb_shield_damage_ctrl.sv
module tb_shield_damage_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0, startOfFrame = 1'b0;
  logic [10:0] offsetX = '0, offsetY = '0;
  logic        insideRectangle = 1'b0, collisionMissile = 1'b0, collisionShot = 1'b0;
  logic [1:0]  rdRow = '0;
  logic [4:0]  rdCol = '0;
  logic [1:0]  rdHealth;
  logic        eraseValid, eraseReady = 1'b0;
  logic [1:0]  eraseRow;
  logic [4:0]  eraseCol;
  logic [6:0]  aliveCount;
  logic        allDestroyed, overflow;

  always #5 clk = ~clk;

  shield_damage_ctrl #(.HIT_POINTS(3), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .offsetX(offsetX), .offsetY(offsetY), .insideRectangle(insideRectangle),
    .collisionMissile(collisionMissile), .collisionShot(collisionShot),
    .rdRow(rdRow), .rdCol(rdCol), .rdHealth(rdHealth),
    .eraseValid(eraseValid), .eraseRow(eraseRow), .eraseCol(eraseCol),
    .eraseReady(eraseReady), .aliveCount(aliveCount),
    .allDestroyed(allDestroyed), .overflow(overflow)
  );

  int n_chk = 0, n_fail = 0, n_pops = 0;
  logic [6:0] exp_erase[$];   // {row,col} in expected erase order
  logic [1:0] exp_rd[$];
  logic rd_req = 1'b0, rd_vld = 1'b0;

  always @(posedge clk) rd_vld <= rd_req;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] ev);
    n_chk++;
    if (act !== ev) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, ev);
    end
  endtask

  // Scoreboard monitor: reads one cycle after request, erases on handshake.
  always @(negedge clk) begin : mon
    logic [6:0] ee;
    logic [1:0] re;
    if (rd_vld) begin
      if (exp_rd.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rd_unexpected: got %0d, expected no read", rdHealth);
      end else begin
        re = exp_rd.pop_front();
        chk("rdHealth", 32'(rdHealth), 32'(re));
      end
    end
    if (!reset && eraseValid && eraseReady) begin
      n_pops++;
      if (exp_erase.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL erase_unexpected: got row %0d col %0d, expected none", eraseRow, eraseCol);
      end else begin
        ee = exp_erase.pop_front();
        chk("erase_cell", 32'({eraseRow, eraseCol}), 32'(ee));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    exp_erase.delete();
  endtask

  task automatic sof();
    startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
  endtask

  task automatic hit_xy(input int x, input int y, input int n, input logic shot);
    offsetX = 11'(x); offsetY = 11'(y); insideRectangle = 1'b1;
    collisionMissile = ~shot; collisionShot = shot;
    repeat (n) tick();
    insideRectangle = 1'b0; collisionMissile = 1'b0; collisionShot = 1'b0;
  endtask

  task automatic rd(input int r, input int c, input logic [1:0] ev);
    rdRow = 2'(r); rdCol = 5'(c); rd_req = 1'b1; exp_rd.push_back(ev);
    tick(); rd_req = 1'b0;
  endtask

  // nf frames, one hit per listed cell per frame; the first nexp kills of
  // the final frame are expected to reach the erase port.
  task automatic hit_frames(input int nf, input logic [6:0] cells[$], input int nexp);
    for (int f = 0; f < nf; f++) begin
      sof();
      for (int k = 0; k < cells.size(); k++) begin
        if (f == nf-1 && k < nexp) exp_erase.push_back(cells[k]);
        hit_xy(int'(cells[k][4:0]) * 32, int'(cells[k][6:5]) * 16, 1, 1'b0);
      end
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && (exp_erase.size() != 0 || eraseValid); i++) tick();
    chk("erase_drained", 32'(exp_erase.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] cl[$];
    int p0;

    // Reset state and full read-back
    do_reset();
    chk("rst_alive", 32'(aliveCount), 32'd72);
    chk("rst_eraseValid", 32'(eraseValid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_rdHealth", 32'(rdHealth), 32'd0);
    chk("rst_allDestroyed", 32'(allDestroyed), 32'd0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 18; c++) rd(r, c, 2'd3);
    rd(0, 18, 2'd0);
    rd(3, 31, 2'd0);
    tick();

    // Held collision within one frame: one decrement only; col 18 ignored
    do_reset();
    sof();
    hit_xy(70, 20, 20, 1'b0);
    rd(1, 2, 2'd2);
    hit_xy(18*32, 0, 3, 1'b0);
    offsetX = 11'd0; insideRectangle = 1'b0; collisionMissile = 1'b1; tick(); collisionMissile = 1'b0;
    rd(0, 0, 2'd3);
    rd(1, 3, 2'd3);
    tick();
    chk("held_alive", 32'(aliveCount), 32'd72);

    // Three frames kill (0,0): exactly one erase; further hits ignored
    do_reset();
    eraseReady = 1'b1;
    p0 = n_pops;
    cl = {7'h00};
    hit_frames(3, cl, 1);
    wait_drain();
    hit_frames(1, cl, 0);
    repeat (3) tick();
    chk("kill_pops", 32'(n_pops - p0), 32'd1);
    chk("kill_alive", 32'(aliveCount), 32'd71);
    rd(0, 0, 2'd0);
    tick();

    // Frame start and hit on the same cycle count in the new frame
    do_reset();
    sof();
    hit_xy(3*32, 2*16, 1, 1'b0);
    startOfFrame = 1'b1; hit_xy(3*32, 2*16, 1, 1'b0); startOfFrame = 1'b0;
    rd(2, 3, 2'd1);
    hit_xy(3*32, 2*16, 2, 1'b0);
    rd(2, 3, 2'd1);
    tick();

    // Player shot alone
    do_reset();
    sof();
    hit_xy(0, 0, 1, 1'b1);
`ifdef SHIELD_PLAYER_DAMAGE_EN
    rd(0, 0, 2'd2);
`else
    rd(0, 0, 2'd3);
`endif
    tick();

    // Queue overflow with bitmap stalled: first 4 in order, fifth dropped
    do_reset();
    eraseReady = 1'b0;
    cl = {7'h00, 7'h01, 7'h02, 7'h03, 7'h04};
    hit_frames(3, cl, 4);
    tick();
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_alive", 32'(aliveCount), 32'd67);
    chk("ovf_valid", 32'(eraseValid), 32'd1);
    repeat (3) tick();
    chk("ovf_head_stable", 32'({eraseRow, eraseCol}), 32'd0);
    rd(0, 4, 2'd0);
    eraseReady = 1'b1;
    wait_drain();
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Reset mid-operation discards queued erase (col 17 boundary cell)
    do_reset();
    eraseReady = 1'b0;
    cl = {{2'd3, 5'd17}};
    hit_frames(3, cl, 0);
    tick();
    chk("mid_valid", 32'(eraseValid), 32'd1);
    chk("mid_head", 32'({eraseRow, eraseCol}), 32'({2'd3, 5'd17}));
    chk("mid_alive", 32'(aliveCount), 32'd71);
    do_reset();
    chk("mid_rst_valid", 32'(eraseValid), 32'd0);
    chk("mid_rst_alive", 32'(aliveCount), 32'd72);
    eraseReady = 1'b1;
    repeat (4) tick();

    // Destroy every cell; push and pop overlap each cycle
    do_reset();
    eraseReady = 1'b1;
    cl.delete();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 18; c++) cl.push_back({2'(r), 5'(c)});
    hit_frames(3, cl, 72);
    wait_drain();
    chk("all_alive", 32'(aliveCount), 32'd0);
    chk("all_destroyed", 32'(allDestroyed), 32'd1);
    chk("all_overflow", 32'(overflow), 32'd0);
    chk("rd_pending", 32'(exp_rd.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
